// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host FSM state codes, keyboard command/response bytes
// and the host-to-device frame builder.
package ps2_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] BITS      = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  // {stop, odd parity, data}; shifted out LSB first after the start bit.
  function automatic logic [9:0] host_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;

  modport master (output tx_data, tx_start,
                  input  tx_busy, tx_done, tx_error, rx_inhibit);
  modport slave  (input  tx_data, tx_start,
                  output tx_busy, tx_done, tx_error, rx_inhibit);
endinterface

// File: rtl/ps2_sync.sv
// 2-FF synchronizer for the PS/2 clock and data pads plus a clock falling-edge strobe.
// Resets to the idle-high line level so reset release never fakes an edge.
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);
  logic [1:0] meta_q, sync_q;
  logic       clk_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      meta_q     <= {ps2_dat_in, ps2_clk_in};
      sync_q     <= meta_q;
      clk_prev_q <= sync_q[0];
    end
  end

  assign clk_s    = sync_q[0];
  assign dat_s    = sync_q[1];
  assign clk_fall = clk_prev_q & ~sync_q[0];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data + odd parity + stop,
// then device ack and bus-idle wait, all bounded by a frame timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 20
) (
  input  logic           clk,
  input  logic           reset,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_dat_in,
  output logic           ps2_clk_oe,
  output logic           ps2_dat_oe
);
  localparam int INH_N = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TO_N  = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int INH_W = $clog2(INH_N + 1);
  localparam int TO_W  = $clog2(TO_N + 1);

  logic clk_s, dat_s, clk_fall;

  ps2_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_s      (clk_s),
    .dat_s      (dat_s),
    .clk_fall   (clk_fall)
  );

  logic [2:0]       state_q, state_d;
  logic [9:0]       sr_q, sr_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timed;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_idx_d = bit_idx_q;
    inh_cnt_d = inh_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timed     = (state_q == BITS) || (state_q == ACK) || (state_q == WAIT_IDLE);
    // Counter runs from the START cycle (value 0) through the end of the frame.
    to_cnt_d  = (timed || state_q == START) ? to_cnt_q + TO_W'(1) : '0;

    if (timed && to_cnt_q == TO_W'(TO_N - 1)) begin
      state_d  = IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      err_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (tx.tx_start) begin
          sr_d      = host_frame(tx.tx_data);
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
        INHIBIT: begin
          if (inh_cnt_q == INH_W'(INH_N - 1)) begin
            dat_oe_d = 1'b1;
            state_d  = START;
          end else begin
            inh_cnt_d = inh_cnt_q + INH_W'(1);
          end
        end
        START: begin
          clk_oe_d  = 1'b0;
          bit_idx_d = '0;
          state_d   = BITS;
        end
        BITS: if (clk_fall) begin
          dat_oe_d  = ~sr_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) state_d = ACK;
        end
        ACK: if (clk_fall) begin
          if (!dat_s) begin
            state_d = WAIT_IDLE;
          end else begin
            state_d  = IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            err_d    = 1'b1;
          end
        end
        WAIT_IDLE: if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d  = IDLE;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_idx_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_idx_q <= bit_idx_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_dat_oe    = dat_oe_q;
  assign tx.tx_busy    = (state_q != IDLE);
  assign tx.rx_inhibit = (state_q != IDLE);
  assign tx.tx_done    = done_q;
  assign tx.tx_error   = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector keyboard model on the pads.
// Timing parameters are scaled down so the whole run stays short.
module tb_ps2_host_tx;
  localparam int CLK_HZ     = 2000000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_MS = 1;
  localparam int INH_N      = 200;   // 2 MHz * 100 us
  localparam int TO_N       = 2000;  // 2 MHz * 1 ms
  localparam int HALF       = 20;    // device clock half period in system clocks

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic ps2_clk_oe, ps2_dat_oe, ps2_clk_in, ps2_dat_in;
  int errors = 0, checks = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, inhib_mis = 0, busy_at_done = 0;

  ps2_host_tx_if tx_if();

  ps2_host_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_MS(TIMEOUT_MS)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx         (tx_if),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_if.tx_done) begin
      done_cnt <= done_cnt + 1;
      if (tx_if.tx_busy) busy_at_done <= busy_at_done + 1;
    end
    if (tx_if.tx_error) err_cnt <= err_cnt + 1;
    if (tx_if.tx_done && tx_if.tx_error) both_cnt <= both_cnt + 1;
    if (tx_if.rx_inhibit !== tx_if.tx_busy) inhib_mis <= inhib_mis + 1;
  end

  // Pulse tx_start, then measure clock-only inhibit cycles and start-bit cycles.
  // Returns at the first negedge of the BITS phase.
  task automatic start_tx(input logic [7:0] d, output int inh, output int st);
    @(negedge clk); tx_if.tx_data = d; tx_if.tx_start = 1'b1;
    @(negedge clk); tx_if.tx_start = 1'b0;
    inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < INH_N + 50) begin inh++; @(negedge clk); end
    st = 0;
    while (ps2_clk_oe && ps2_dat_oe && st < 10) begin st++; @(negedge clk); end
  endtask

  // Keyboard model: 11 clocks, samples start+10 bits, drives ack before the 11th edge.
  task automatic dev_frame(input bit ack, input int abort_edge, input bit inject,
                           output logic [10:0] bits);
    bits = '0;
    repeat (HALF) @(negedge clk);
    bits[0] = ps2_dat_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        repeat (HALF/2) @(negedge clk);
        dev_dat_low = ack;
        repeat (HALF/2) @(negedge clk);
      end else if (k > 1) begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (inject && k == 3) begin
        tx_if.tx_data = 8'hAA; tx_if.tx_start = 1'b1;
        @(negedge clk); tx_if.tx_start = 1'b0;
        repeat (HALF-1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (k <= 10) bits[k] = ps2_dat_in;
      if (k == abort_edge) return;
      dev_clk_low = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_if.tx_busy && n < 200) begin n++; @(negedge clk); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
    checks++; if (tx_if.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_if.tx_busy); end
    checks++; if (tx_if.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_if.tx_done); end
    checks++; if (tx_if.tx_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", tx_if.tx_error); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame_ed();
    int inh, st, d0, e0;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED, inh, st);
    checks++; if (inh !== INH_N) begin errors++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH_N); end
    checks++; if (st !== 1) begin errors++; $display("FAIL ed_start_len: got %0d want 1", st); end
    checks++; if (tx_if.tx_busy !== 1'b1) begin errors++; $display("FAIL ed_busy_mid: got %b want 1", tx_if.tx_busy); end
    dev_frame(1'b1, 0, 1'b0, bits);
    wait_idle();
    checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL ed_bits: got %h want 7da", bits); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ed_done: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL ed_error: got %0d want 0", err_cnt - e0); end
    checks++; if (busy_at_done !== 0) begin errors++; $display("FAIL ed_busy_at_done: got %0d want 0", busy_at_done); end
    checks++; if (inhib_mis !== 0) begin errors++; $display("FAIL ed_rx_inhibit: got %0d want 0", inhib_mis); end
  endtask

  task automatic test_parity();
    logic [7:0]  din [3] = '{8'h01, 8'h00, 8'hFF};
    logic [10:0] exp [3] = '{11'h402, 11'h600, 11'h7FE};
    int inh, st, d0;
    logic [10:0] bits;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      start_tx(din[i], inh, st);
      dev_frame(1'b1, 0, 1'b0, bits);
      wait_idle();
      checks++; if (bits !== exp[i]) begin errors++; $display("FAIL parity_bits_%h: got %h want %h", din[i], bits, exp[i]); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL parity_done_%h: got %0d want 1", din[i], done_cnt - d0); end
    end
  endtask

  task automatic test_nack();
    int inh, st, d0, e0;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hEE, inh, st);
    dev_frame(1'b0, 0, 1'b0, bits);
    wait_idle();
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL nack_error: got %0d want 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL nack_done: got %0d want 0", done_cnt - d0); end
    checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL nack_lines: got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
    checks++; if (tx_if.tx_busy !== 1'b0) begin errors++; $display("FAIL nack_busy: got %b want 0", tx_if.tx_busy); end
  endtask

  task automatic test_timeout();
    int inh, st, n, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF, inh, st);
    n = 1;  // start_tx returns one cycle after the START cycle
    while (!tx_if.tx_error && n < TO_N + 100) begin @(negedge clk); n++; end
    checks++; if (n !== TO_N) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", n, TO_N); end
    checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL timeout_lines: got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
    checks++; if (tx_if.tx_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", tx_if.tx_busy); end
    repeat (3) @(negedge clk);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_error: got %0d want 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_ignore_start();
    int inh, st, d0;
    logic [10:0] bits;
    d0 = done_cnt;
    start_tx(8'hED, inh, st);
    dev_frame(1'b1, 0, 1'b1, bits);
    wait_idle();
    checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL ignore_bits: got %h want 7da", bits); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int inh, st, d0, e0;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h5A, inh, st);
    dev_frame(1'b1, 4, 1'b0, bits);
    checks++; if (tx_if.tx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", tx_if.tx_busy); end
    reset = 1'b1;
    #1;
    checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL rstmid_lines: got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
    checks++; if (tx_if.tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", tx_if.tx_busy); end
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin errors++; $display("FAIL rstmid_pulses: got %0d want 0", (done_cnt - d0) + (err_cnt - e0)); end
    d0 = done_cnt;
    start_tx(8'hEE, inh, st);
    checks++; if (inh !== INH_N) begin errors++; $display("FAIL rstmid_inhibit_len: got %0d want %0d", inh, INH_N); end
    dev_frame(1'b1, 0, 1'b0, bits);
    wait_idle();
    checks++; if (bits !== 11'h7DC) begin errors++; $display("FAIL rstmid_bits: got %h want 7dc", bits); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done: got %0d want 1", done_cnt - d0); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_and_error_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    tx_if.tx_data = 8'h00;
    tx_if.tx_start = 1'b0;
    test_reset();
    test_frame_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish within 60000 cycles, want finish");
    $fatal(1);
  end
endmodule
